// File: rtl/process_scheduler.sv
// Round-robin time-slice scheduler: picks the next ready process, loads its base
// into the instruction-memory relocation path, and requests OS swaps on expiry/halt.
//
// state  | meaning
// IDLE   | OS mode, nothing scheduled
// SELECT | search slot table for next ready process
// LOAD   | flagShift pulse, base presented on shift
// RUN    | user process executing, quantum counting down
// SWAP   | swapReq held until OS acks
module process_scheduler #(
  parameter int NUM_PROC = 4,
  parameter int ADDR_W   = 12,
  parameter int QUANT_W  = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [QUANT_W-1:0]          quantum,
  input  logic                        instrRetired,
  input  logic                        procHalt,
  input  logic                        cfgWe,
  input  logic [$clog2(NUM_PROC)-1:0] cfgSlot,
  input  logic [ADDR_W-1:0]           cfgBase,
  input  logic                        cfgValid,
  input  logic                        ack,
  output logic [ADDR_W-1:0]           shift,
  output logic                        flagShift,
  output logic                        flagSO,
  output logic [$clog2(NUM_PROC)-1:0] curProc,
  output logic                        swapReq,
  output logic                        idle
);

  localparam int SLOT_W = $clog2(NUM_PROC);

  typedef enum logic [2:0] {IDLE, SELECT, LOAD, RUN, SWAP} stateType;

  stateType            state, nextState;
  logic [ADDR_W-1:0]   base [NUM_PROC];
  logic [NUM_PROC-1:0] valid;
  logic [QUANT_W-1:0]  counter;
  logic                started;
  logic                anyValid;
  logic                found;
  logic [SLOT_W-1:0]   searchBase;
  logic [SLOT_W-1:0]   nextSlot;

  assign anyValid = |valid;

  // Before any process has run the search starts at slot 0 rather than after curProc.
  assign searchBase = started ? curProc : {SLOT_W{1'b1}};

  always_comb begin
    found    = 1'b0;
    nextSlot = curProc;
    for (int i = NUM_PROC; i >= 1; i--) begin
      if (valid[searchBase + SLOT_W'(i)]) begin
        found    = 1'b1;
        nextSlot = searchBase + SLOT_W'(i);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:   if (enable && anyValid) nextState = SELECT;
      SELECT: nextState = found ? LOAD : IDLE;
      LOAD:   nextState = RUN;
      RUN:    if (procHalt || !enable || (instrRetired && counter == QUANT_W'(1)))
                nextState = SWAP;
      SWAP:   if (ack) nextState = (enable && anyValid) ? SELECT : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift     <= '0;
      flagShift <= 1'b0;
      flagSO    <= 1'b0;
      curProc   <= '0;
      swapReq   <= 1'b0;
      idle      <= 1'b1;
      counter   <= '0;
      started   <= 1'b0;
      valid     <= '0;
      for (int i = 0; i < NUM_PROC; i++) base[i] <= '0;
    end else begin
      flagShift <= (nextState == LOAD);
      flagSO    <= (nextState == RUN);
      swapReq   <= (nextState == SWAP);
      idle      <= (nextState == IDLE);
      if (state == SELECT && found) begin
        shift   <= base[nextSlot];
        curProc <= nextSlot;
        started <= 1'b1;
        counter <= (quantum == '0) ? QUANT_W'(1) : quantum;
      end
      if (state == RUN && instrRetired && counter != '0) counter <= counter - QUANT_W'(1);
      if (state == RUN && procHalt) valid[curProc] <= 1'b0;
      // A same-cycle table write overrides the halt clear above.
      if (cfgWe) begin
        valid[cfgSlot] <= cfgValid;
        base[cfgSlot]  <= cfgBase;
      end
    end
  end

endmodule

// File: tb/tb_process_scheduler.sv
// Directed bench for process_scheduler: behavioural slot/slice model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_process_scheduler;

  localparam int NP = 4;
  localparam int AW = 12;
  localparam int QW = 8;
  localparam int SW = 2;

  localparam int PH_IDLE = 0, PH_SELECT = 1, PH_LOAD = 2, PH_RUN = 3, PH_SWAP = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [QW-1:0] quantum = '0;
  logic          instrRetired = 1'b0;
  logic          procHalt = 1'b0;
  logic          cfgWe = 1'b0;
  logic [SW-1:0] cfgSlot = '0;
  logic [AW-1:0] cfgBase = '0;
  logic          cfgValid = 1'b0;
  logic          ack = 1'b0;
  logic [AW-1:0] shift;
  logic          flagShift;
  logic          flagSO;
  logic [SW-1:0] curProc;
  logic          swapReq;
  logic          idle;

  int compared = 0;
  int mismatched = 0;

  process_scheduler #(.NUM_PROC(NP), .ADDR_W(AW), .QUANT_W(QW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .quantum(quantum),
    .instrRetired(instrRetired), .procHalt(procHalt), .cfgWe(cfgWe),
    .cfgSlot(cfgSlot), .cfgBase(cfgBase), .cfgValid(cfgValid), .ack(ack),
    .shift(shift), .flagShift(flagShift), .flagSO(flagSO), .curProc(curProc),
    .swapReq(swapReq), .idle(idle)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: slot table, round-robin pick by modulo scan, slice budget.
  int mValid [NP];
  int mBase  [NP];
  int mCur, mCount, mPhase, mAny, mNext, mFirst, mIdx;
  bit mStarted, mLeave;
  int eShift, eCur;
  bit eFlagShift, eFlagSO, eSwap, eIdle;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NP; k++) begin
        mValid[k] = 0;
        mBase[k]  = 0;
      end
      mCur = 0; mCount = 0; mPhase = PH_IDLE; mStarted = 0;
      eShift = 0; eCur = 0; eFlagShift = 0; eFlagSO = 0; eSwap = 0; eIdle = 1;
    end else begin
      mAny = 0;
      for (int k = 0; k < NP; k++) mAny += mValid[k];
      mNext = mPhase;
      case (mPhase)
        PH_IDLE: if (enable && mAny > 0) mNext = PH_SELECT;
        PH_SELECT: begin
          mNext  = PH_IDLE;
          mFirst = mStarted ? mCur + 1 : 0;
          for (int k = 0; k < NP; k++) begin
            mIdx = (mFirst + k) % NP;
            if (mNext == PH_IDLE && mValid[mIdx] != 0) begin
              mNext    = PH_LOAD;
              mCur     = mIdx;
              eShift   = mBase[mIdx];
              mCount   = (quantum == 0) ? 1 : int'(quantum);
              mStarted = 1;
            end
          end
        end
        PH_LOAD: mNext = PH_RUN;
        PH_RUN: begin
          mLeave = procHalt || !enable || (instrRetired && mCount == 1);
          if (procHalt) mValid[mCur] = 0;
          if (instrRetired) mCount--;
          if (mLeave) mNext = PH_SWAP;
        end
        PH_SWAP: if (ack) mNext = (enable && mAny > 0) ? PH_SELECT : PH_IDLE;
        default: mNext = PH_IDLE;
      endcase
      if (cfgWe) begin
        mValid[cfgSlot] = cfgValid;
        mBase[cfgSlot]  = cfgBase;
      end
      mPhase     = mNext;
      eCur       = mCur;
      eFlagShift = (mPhase == PH_LOAD);
      eFlagSO    = (mPhase == PH_RUN);
      eSwap      = (mPhase == PH_SWAP);
      eIdle      = (mPhase == PH_IDLE);
    end
  end

  always @(negedge clock) begin
    check("shift", shift, eShift);
    check("flagShift", flagShift, eFlagShift);
    check("flagSO", flagSO, eFlagSO);
    check("curProc", curProc, eCur);
    check("swapReq", swapReq, eSwap);
    check("idle", idle, eIdle);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg(input int slot, input int b, input bit v);
    cfgWe = 1'b1; cfgSlot = SW'(slot); cfgBase = AW'(b); cfgValid = v;
    tick();
    cfgWe = 1'b0;
  endtask

  task automatic waitShift(input string name);
    for (int i = 0; i < 10 && !flagShift; i++) tick();
    check(name, flagShift, 1);
  endtask

  task automatic pulseRetire();
    instrRetired = 1'b1;
    tick();
    instrRetired = 1'b0;
  endtask

  task automatic ackSwap();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    reset = 1'b1;
    check("rst idle", idle, 1);
    check("rst flagSO", flagSO, 0);
    check("rst swapReq", swapReq, 0);
    check("rst shift", shift, 0);
    check("rst curProc", curProc, 0);

    // ack and instrRetired outside SWAP/RUN are ignored
    ack = 1'b1; instrRetired = 1'b1; tick();
    ack = 1'b0; instrRetired = 1'b0; tick();
    check("idle no enable", idle, 1);

    // 1: first selection starts at slot 0
    cfg(0, 'h100, 1);
    cfg(2, 'h300, 1);
    quantum = 8'd3; enable = 1'b1;
    waitShift("t1 flagShift");
    check("t1 shift", shift, 'h100);
    check("t1 curProc", curProc, 0);
    tick();
    check("t1 flagSO", flagSO, 1);

    // 2: quantum expiry, slot1 skipped
    repeat (2) begin pulseRetire(); tick(); end
    check("t2 no swap yet", swapReq, 0);
    pulseRetire();
    check("t2 swapReq", swapReq, 1);
    check("t2 flagSO off", flagSO, 0);
    tick(); tick();
    check("t2 swap held", swapReq, 1);
    ackSwap();
    check("t2 swap drop", swapReq, 0);
    tick();
    check("t2 flagShift", flagShift, 1);
    check("t2 shift", shift, 'h300);
    check("t2 curProc", curProc, 2);
    check("t2 model curProc", eCur, 2);
    tick();
    check("t2 flagSO", flagSO, 1);

    // 3: halt slot2, only slot0 remains
    procHalt = 1'b1; tick(); procHalt = 1'b0;
    check("t3 swapReq", swapReq, 1);
    ackSwap(); tick(); tick();
    check("t3 flagSO", flagSO, 1);
    check("t3 curProc", curProc, 0);
    check("t3 shift", shift, 'h100);
    repeat (3) pulseRetire();
    check("t3 expiry", swapReq, 1);

    // 4: quantum 0 behaves as 1
    quantum = 8'd0;
    ackSwap();
    waitShift("t3 reselect");
    check("t3 reselect curProc", curProc, 0);
    check("t3 model shift", eShift, 'h100);
    tick();
    pulseRetire();
    check("t4 swap1", swapReq, 1);
    ackSwap(); tick(); tick();
    check("t4 run2", flagSO, 1);
    pulseRetire();
    check("t4 swap2", swapReq, 1);

    // 5: halt together with final retire, last process gone
    quantum = 8'd2;
    ackSwap(); tick(); tick();
    check("t5 run", flagSO, 1);
    pulseRetire();
    check("t5 no swap", swapReq, 0);
    instrRetired = 1'b1; procHalt = 1'b1; tick();
    instrRetired = 1'b0; procHalt = 1'b0;
    check("t5 swapReq", swapReq, 1);
    repeat (3) tick();
    ackSwap();
    check("t5 idle", idle, 1);
    check("t5 flagSO", flagSO, 0);
    repeat (4) tick();
    check("t5 no flagShift", flagShift, 0);

    // cfg write on running slot beats halt; new base seen at next LOAD
    cfg(1, 'h200, 1);
    waitShift("cw flagShift");
    check("cw curProc", curProc, 1);
    check("cw shift", shift, 'h200);
    tick();
    procHalt = 1'b1; cfgWe = 1'b1; cfgSlot = 2'd1; cfgBase = 12'h250; cfgValid = 1'b1;
    tick();
    procHalt = 1'b0; cfgWe = 1'b0;
    check("cw swapReq", swapReq, 1);
    ackSwap();
    waitShift("cw reselect");
    check("cw reselect curProc", curProc, 1);
    check("cw new base", shift, 'h250);
    tick();

    // enable drop forces a swap, then idle on ack
    enable = 1'b0; tick();
    check("en swapReq", swapReq, 1);
    ackSwap();
    check("en idle", idle, 1);

    // 6: asynchronous reset while running
    enable = 1'b1;
    waitShift("t6 flagShift");
    tick();
    check("t6 running", flagSO, 1);
    @(posedge clock); #3;
    reset = 1'b0; #1;
    check("t6 flagSO", flagSO, 0);
    check("t6 idle", idle, 1);
    check("t6 shift", shift, 0);
    check("t6 curProc", curProc, 0);
    check("t6 swapReq", swapReq, 0);
    check("t6 flagShift", flagShift, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (5) tick();
    check("t6 stays idle", idle, 1);
    check("t6 no run", flagSO, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
